// File: rtl/cpu_mem_responder_if.sv
// CPU-to-memory single-port request/response bundle.
// The CPU drives the master side; the memory responder drives the slave side.
interface cpu_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        proto_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, busy, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, busy, proto_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word-organised memory that answers CPU read/write requests after a fixed latency.
// Each access ends with a one-cycle mem_resp pulse. A sticky proto_err records bus misuse.
module cpu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_mem_responder_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           resp_q, resp_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           busy_q, busy_d;
    logic           perr_q, perr_d;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           req;
    logic           commit;
    logic           eff_wr;
    logic [AW-1:0]  eff_idx;
    logic [3:0]     eff_be;
    logic [31:0]    eff_wdata;
    logic           mismatch;

    assign req = bus.mem_read | bus.mem_write;

    // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs stand in for the latch.
    always_comb begin
        if (state_q == S_IDLE) begin
            eff_wr    = bus.mem_write;
            eff_idx   = bus.mem_address[AW+1:2];
            eff_be    = bus.mem_byte_enable;
            eff_wdata = bus.mem_wdata;
        end else begin
            eff_wr    = wr_q;
            eff_idx   = addr_q[AW+1:2];
            eff_be    = be_q;
            eff_wdata = wdata_q;
        end
    end

    assign mismatch = (bus.mem_address != addr_q) || (bus.mem_byte_enable != be_q) ||
                      (bus.mem_wdata != wdata_q) || (bus.mem_write != wr_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = bus.mem_write;
                    addr_d  = bus.mem_address;
                    be_d    = bus.mem_byte_enable;
                    wdata_d = bus.mem_wdata;
                    if (LATENCY == 1) begin
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic (registered outputs, next values computed here)
    always_comb begin
        commit  = (state_d == S_RESP) && (state_q != S_RESP);
        resp_d  = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        rdata_d = (commit && !eff_wr) ? mem_q[eff_idx] : rdata_q;
        perr_d  = perr_q;
        if (state_q == S_IDLE && bus.mem_read && bus.mem_write) begin
            perr_d = 1'b1;
        end
        if (state_q == S_WAIT && req && mismatch) begin
            perr_d = 1'b1;
        end
    end

    // Array is deliberately not reset; a commit racing an asserted rst is dropped.
    always_ff @(posedge clk) begin
        if (commit && eff_wr && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (eff_be[i]) begin
                    mem_q[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder (DEPTH_WORDS=1024, LATENCY=3).
// Read expectations go through a scoreboard queue and are popped when mem_resp is seen.
module tb_cpu_mem_responder;
    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    logic [31:0] exp_q[$];

    cpu_mem_responder_if bus();

    cpu_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Raises a request, holds it until mem_resp (bounded), then drops it on the next edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int lat, output int busyc, output logic [31:0] rdat,
                          output int rcyc, output bit tmo);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        @(posedge clk);
        lat = 0; busyc = 0; rdat = 'x; rcyc = 0; tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busyc++;
            if (bus.mem_resp) begin
                tmo  = 1'b0;
                rdat = bus.mem_rdata;
                rcyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        int lat, busyc, rcyc, seen;
        bit tmo;
        logic [31:0] rd, e;
        rst = 1'b1;
        bus.mem_read = 1'b1; bus.mem_write = 1'b1;
        bus.mem_address = 32'h10; bus.mem_byte_enable = 4'hF; bus.mem_wdata = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.mem_resp, bus.busy, bus.proto_err, bus.mem_rdata} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got resp=%b busy=%b perr=%b rdata=%h, want all 0",
                     bus.mem_resp, bus.busy, bus.proto_err, bus.mem_rdata);
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_resp || bus.busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_release_quiet: got %0d active cycles, want 0", seen);
        end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h1C, 4'hF, 32'hA5A5_A5A5, lat, busyc, rd, rcyc, tmo);
        // Start a write, then hit rst mid-access.
        bus.mem_write = 1'b1; bus.mem_address = 32'h1C; bus.mem_wdata = 32'h1234_5678;
        bus.mem_byte_enable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.mem_resp, bus.busy, bus.proto_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_access: got resp=%b busy=%b perr=%b, want 000",
                     bus.mem_resp, bus.busy, bus.proto_err);
        end
        bus.mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'hA5A5_A5A5);
        access(1'b1, 1'b0, 32'h1C, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL reset_drops_write: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
    endtask

    task automatic test_read_latency();
        int lat, busyc, rcyc;
        bit tmo;
        logic [31:0] rd, e;
        access(1'b0, 1'b1, 32'h14, 4'hF, 32'hDEAD_BEEF, lat, busyc, rd, rcyc, tmo);
        total++;
        if (tmo || lat !== 3) begin
            bad++;
            $display("FAIL write_latency: got %0d (timeout=%0d), want 3", lat, tmo);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL read_data: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL read_latency: got %0d, want 3", lat);
        end
        total++;
        if (busyc !== 3) begin
            bad++;
            $display("FAIL read_busy_cycles: got %0d, want 3", busyc);
        end
        @(negedge clk);
        total++;
        if ({bus.mem_resp, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL resp_single_pulse: got resp=%b busy=%b, want 00", bus.mem_resp, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_enable();
        int lat, busyc, rcyc;
        bit tmo;
        logic [31:0] rd, e;
        access(1'b0, 1'b1, 32'h08, 4'hF, 32'hFFFF_FFFF, lat, busyc, rd, rcyc, tmo);
        access(1'b0, 1'b1, 32'h08, 4'b0101, 32'h1122_3344, lat, busyc, rd, rcyc, tmo);
        exp_q.push_back(32'hFF22_FF44);
        access(1'b1, 1'b0, 32'h0A, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL byte_enable_read: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
        access(1'b0, 1'b1, 32'h08, 4'b0000, 32'h0000_0000, lat, busyc, rd, rcyc, tmo);
        total++;
        if (tmo || lat !== 3) begin
            bad++;
            $display("FAIL be0_write_resp: got latency %0d (timeout=%0d), want 3", lat, tmo);
        end
        total++;
        if (rd !== 32'hFF22_FF44) begin
            bad++;
            $display("FAIL rdata_hold_on_write: got %h, want ff22ff44", rd);
        end
        exp_q.push_back(32'hFF22_FF44);
        access(1'b1, 1'b0, 32'h08, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL be0_noop: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busyc, c1, c2;
        bit tmo1, tmo2;
        logic [31:0] rd, e;
        access(1'b0, 1'b1, 32'h30, 4'hF, 32'hCAFE_F00D, lat, busyc, rd, c1, tmo1);
        exp_q.push_back(32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat, busyc, rd, c2, tmo2);
        e = exp_q.pop_front();
        total++;
        if (tmo1 || tmo2 || (c2 - c1) !== 4) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles (timeouts=%0d%0d), want 4", c2 - c1, tmo1, tmo2);
        end
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL b2b_read: got %h, want %h", rd, e);
        end
        total++;
        if (bus.proto_err !== 1'b0) begin
            bad++;
            $display("FAIL no_proto_err_clean: got %b, want 0", bus.proto_err);
        end
    endtask

    task automatic test_abort_wrap();
        int lat, busyc, rcyc, seen;
        bit tmo;
        logic [31:0] rd, e;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = 32'h14;
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_resp) seen++;
        end
        total++;
        if (seen !== 0 || bus.proto_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort: got resps=%0d perr=%b busy=%b, want 0 0 0", seen, bus.proto_err, bus.busy);
        end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h0BAD_CAFE, lat, busyc, rd, rcyc, tmo);
        exp_q.push_back(32'h0BAD_CAFE);
        access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL addr_wrap: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
    endtask

    task automatic test_violations();
        int lat, busyc, rcyc;
        bit tmo;
        logic [31:0] rd, e;
        access(1'b0, 1'b1, 32'h28, 4'hF, 32'h0000_0000, lat, busyc, rd, rcyc, tmo);
        // Address moves during WAIT; the latched address must win.
        bus.mem_write = 1'b1; bus.mem_address = 32'h24; bus.mem_wdata = 32'h55AA_55AA;
        bus.mem_byte_enable = 4'hF;
        @(posedge clk);
        #1;
        bus.mem_address = 32'h28;
        tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                tmo = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        total++;
        if (tmo || bus.proto_err !== 1'b1) begin
            bad++;
            $display("FAIL addr_change_err: got perr=%b (timeout=%0d), want 1", bus.proto_err, tmo);
        end
        exp_q.push_back(32'h55AA_55AA);
        access(1'b1, 1'b0, 32'h24, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL addr_change_latched: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
        exp_q.push_back(32'h0000_0000);
        access(1'b1, 1'b0, 32'h28, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL addr_change_untouched: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
        access(1'b1, 1'b1, 32'h40, 4'hF, 32'h0BAD_F00D, lat, busyc, rd, rcyc, tmo);
        total++;
        if (tmo || rd !== 32'h0000_0000) begin
            bad++;
            $display("FAIL both_high_is_write: got rdata %h (timeout=%0d), want 00000000", rd, tmo);
        end
        exp_q.push_back(32'h0BAD_F00D);
        access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, busyc, rd, rcyc, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || rd !== e) begin
            bad++;
            $display("FAIL both_high_commit: got %h (timeout=%0d), want %h", rd, tmo, e);
        end
        total++;
        if (bus.proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_err_sticky: got %b, want 1", bus.proto_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.proto_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_err_cleared: got %b, want 0", bus.proto_err);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_byte_enable = 4'h0; bus.mem_address = '0; bus.mem_wdata = '0;
        test_reset();
        test_read_latency();
        test_byte_enable();
        test_back_to_back();
        test_abort_wrap();
        test_violations();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
